// File: rtl/microinstruction_pipe_register.sv
// Negedge-clocked microinstruction pipeline register with stall/flush control,
// per-stage valid bits and a trace FIFO of retired state numbers.
module microinstruction_pipe_register #(
    parameter int unsigned      WIDTH       = 64,
    parameter int unsigned      STATE_W     = 9,
    parameter int unsigned      DEPTH       = 1,
    parameter int unsigned      TRACE_DEPTH = 8,
    parameter logic [WIDTH-1:0] NOP_WORD    = '0
) (
    input  logic                                 Clock,
    input  logic                                 Reset_n,
    input  logic [WIDTH-1:0]                     Word_In,
    input  logic [STATE_W-1:0]                   State_In,
    input  logic                                 Word_Valid,
    input  logic                                 Stall,
    input  logic                                 Flush,
    output logic [WIDTH-1:0]                     Word_Out,
    output logic [STATE_W-1:0]                   State_Out,
    output logic                                 Word_Out_Valid,
    input  logic                                 Trace_Rd,
    input  logic                                 Trace_Clear,
    output logic [STATE_W-1:0]                   Trace_State,
    output logic [$clog2(TRACE_DEPTH+1)-1:0]     Trace_Count,
    output logic                                 Trace_Overflow
);

    localparam int unsigned PTR_W = $clog2(TRACE_DEPTH);
    localparam int unsigned CNT_W = $clog2(TRACE_DEPTH + 1);

    logic [WIDTH-1:0]   word_q  [DEPTH];
    logic [STATE_W-1:0] state_q [DEPTH];
    logic               valid_q [DEPTH];

    logic               advance;
    logic               entering_valid;
    logic [STATE_W-1:0] entering_state;

    assign advance = !Flush && !Stall;

    // The word about to land in the last stage: straight from the input when
    // there is only one stage, otherwise from the stage before the last.
    generate
        if (DEPTH == 1) begin : g_single
            assign entering_valid = Word_Valid;
            assign entering_state = State_In;
        end else begin : g_multi
            assign entering_valid = valid_q[DEPTH-2];
            assign entering_state = state_q[DEPTH-2];
        end
    endgenerate

    always_ff @(negedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                word_q[i]  <= NOP_WORD;
                state_q[i] <= '0;
                valid_q[i] <= 1'b0;
            end
        end else if (Flush) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                word_q[i]  <= NOP_WORD;
                state_q[i] <= '0;
                valid_q[i] <= 1'b0;
            end
        end else if (!Stall) begin
            word_q[0]  <= Word_In;
            state_q[0] <= State_In;
            valid_q[0] <= Word_Valid;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                word_q[i]  <= word_q[i-1];
                state_q[i] <= state_q[i-1];
                valid_q[i] <= valid_q[i-1];
            end
        end
    end

    assign Word_Out       = word_q[DEPTH-1];
    assign State_Out      = state_q[DEPTH-1];
    assign Word_Out_Valid = valid_q[DEPTH-1];

    logic [STATE_W-1:0] trace_mem [TRACE_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   trace_cnt;
    logic               trace_ovf;
    logic               push;
    logic               pop;
    logic               full;

    assign push = advance && entering_valid;
    assign pop  = Trace_Rd && (trace_cnt != '0);
    assign full = (trace_cnt == CNT_W'(TRACE_DEPTH));

    always_ff @(negedge Clock) begin
        if (push && !Trace_Clear) begin
            trace_mem[wr_ptr] <= entering_state;
        end
    end

    // A push into a full FIFO drops the oldest entry by advancing the read
    // pointer alongside the write pointer; a simultaneous pop already does that.
    always_ff @(negedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trace_cnt <= '0;
            trace_ovf <= 1'b0;
        end else if (Trace_Clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            trace_cnt <= '0;
            trace_ovf <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (push && pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end else if (push) begin
                if (full) begin
                    rd_ptr    <= rd_ptr + PTR_W'(1);
                    trace_ovf <= 1'b1;
                end else begin
                    trace_cnt <= trace_cnt + CNT_W'(1);
                end
            end else if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                trace_cnt <= trace_cnt - CNT_W'(1);
            end
        end
    end

    assign Trace_State    = (trace_cnt == '0) ? '0 : trace_mem[rd_ptr];
    assign Trace_Count    = trace_cnt;
    assign Trace_Overflow = trace_ovf;

endmodule

// File: tb/tb_microinstruction_pipe_register.sv
// Directed bench for microinstruction_pipe_register (DEPTH=2, TRACE_DEPTH=8)
// against a queue-based behavioural model plus literal spot checks.
module tb_microinstruction_pipe_register;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned TDEP  = 8;
    localparam logic [63:0] NOP   = 64'hDEAD_0000_0000_BEEF;

    logic        Clock;
    logic        Reset_n;
    logic [63:0] Word_In;
    logic [8:0]  State_In;
    logic        Word_Valid;
    logic        Stall;
    logic        Flush;
    logic [63:0] Word_Out;
    logic [8:0]  State_Out;
    logic        Word_Out_Valid;
    logic        Trace_Rd;
    logic        Trace_Clear;
    logic [8:0]  Trace_State;
    logic [3:0]  Trace_Count;
    logic        Trace_Overflow;

    microinstruction_pipe_register #(
        .WIDTH       (64),
        .STATE_W     (9),
        .DEPTH       (DEPTH),
        .TRACE_DEPTH (TDEP),
        .NOP_WORD    (NOP)
    ) dut (
        .Clock          (Clock),
        .Reset_n        (Reset_n),
        .Word_In        (Word_In),
        .State_In       (State_In),
        .Word_Valid     (Word_Valid),
        .Stall          (Stall),
        .Flush          (Flush),
        .Word_Out       (Word_Out),
        .State_Out      (State_Out),
        .Word_Out_Valid (Word_Out_Valid),
        .Trace_Rd       (Trace_Rd),
        .Trace_Clear    (Trace_Clear),
        .Trace_State    (Trace_State),
        .Trace_Count    (Trace_Count),
        .Trace_Overflow (Trace_Overflow)
    );

    initial Clock = 1'b1;
    always #5 Clock = ~Clock;

    typedef struct {
        logic [63:0] w;
        logic [8:0]  s;
        logic        v;
    } rec_t;

    rec_t       pipe[$];
    logic [8:0] tq[$];
    logic       m_ovf;

    // Model: the pipeline is a queue whose back is the last stage; the trace
    // is a plain queue capped at TDEP entries.
    always @(negedge Clock or negedge Reset_n) begin : model
        rec_t r;
        bit   do_pop;
        if (!Reset_n) begin
            pipe.delete();
            for (int i = 0; i < DEPTH; i++) pipe.push_back('{NOP, 9'd0, 1'b0});
            tq.delete();
            m_ovf = 1'b0;
        end else if (Flush) begin
            for (int i = 0; i < DEPTH; i++) pipe[i] = '{NOP, 9'd0, 1'b0};
        end else if (!Stall) begin
            r = '{Word_In, State_In, Word_Valid};
            pipe.push_front(r);
            void'(pipe.pop_back());
            do_pop = Trace_Rd && (tq.size() > 0);
            if (Trace_Clear) begin
                tq.delete();
                m_ovf = 1'b0;
            end else begin
                if (do_pop) void'(tq.pop_front());
                if (pipe[DEPTH-1].v) tq.push_back(pipe[DEPTH-1].s);
                if (tq.size() > TDEP) begin
                    void'(tq.pop_front());
                    m_ovf = 1'b1;
                end
            end
        end else begin
            if (Trace_Clear) begin
                tq.delete();
                m_ovf = 1'b0;
            end else if (Trace_Rd && tq.size() > 0) begin
                void'(tq.pop_front());
            end
        end
    end

    int unsigned vectors;
    int unsigned miscompares;
    bit          cmp_en;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input logic [63:0] w, input logic [8:0] s, input logic v,
                        input logic st, input logic fl, input logic rd, input logic clr);
        Word_In     = w;
        State_In    = s;
        Word_Valid  = v;
        Stall       = st;
        Flush       = fl;
        Trace_Rd    = rd;
        Trace_Clear = clr;
        @(negedge Clock);
        #2;
    endtask

    task automatic idle(input logic rd, input logic clr);
        tick(64'h5555_5555_5555_5555, 9'h055, 1'b0, 1'b0, 1'b0, rd, clr);
    endtask

    function automatic logic [63:0] wrd(input logic [8:0] s);
        return {32'hA5A5_0000, 23'd0, s};
    endfunction

    localparam logic [63:0] A = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] B = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] C = 64'hCCCC_CCCC_CCCC_CCCC;

    initial begin
        vectors     = 0;
        miscompares = 0;
        cmp_en      = 1'b0;
        Reset_n     = 1'b1;
        Word_In     = '0;
        State_In    = '0;
        Word_Valid  = 1'b0;
        Stall       = 1'b0;
        Flush       = 1'b0;
        Trace_Rd    = 1'b0;
        Trace_Clear = 1'b0;
        #1 Reset_n = 1'b0;
        #1;
        cmp_en = 1'b1;
        fork
            begin : compare
                forever begin
                    @(posedge Clock);
                    if (cmp_en) begin
                        chk("word_out",    Word_Out,       pipe[DEPTH-1].w);
                        chk("state_out",   State_Out,      pipe[DEPTH-1].s);
                        chk("valid_out",   Word_Out_Valid, pipe[DEPTH-1].v);
                        chk("trace_count", Trace_Count,    tq.size());
                        chk("trace_state", Trace_State,    tq.size() > 0 ? tq[0] : 9'd0);
                        chk("trace_ovf",   Trace_Overflow, m_ovf);
                    end
                end
            end
            begin : stimulus
                chk("rst_word",  Word_Out, NOP);
                chk("rst_valid", Word_Out_Valid, 0);
                chk("rst_count", Trace_Count, 0);
                chk("rst_ovf",   Trace_Overflow, 0);
                @(negedge Clock);
                #2;
                chk("rst_hold_word", Word_Out, NOP);
                Reset_n = 1'b1;

                tick(A, 9'h010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("lat_first_valid", Word_Out_Valid, 0);
                tick(B, 9'h011, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("lat_a_word",  Word_Out, A);
                chk("lat_a_state", State_Out, 9'h010);
                chk("lat_a_count", Trace_Count, 1);

                for (int k = 0; k < 3; k++) begin
                    tick(64'h1111_1111_1111_1111, 9'h0EE, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                    chk("stall_word",  Word_Out, A);
                    chk("stall_count", Trace_Count, 1);
                end
                tick(64'hDDDD_0000_DDDD_0000, 9'h0DD, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("unstall_word", Word_Out, B);
                chk("unstall_count", Trace_Count, 2);
                chk("unstall_tstate", Trace_State, 9'h010);

                tick(C, 9'h0CC, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                chk("flush_word",  Word_Out, NOP);
                chk("flush_valid", Word_Out_Valid, 0);
                chk("flush_state", State_Out, 0);
                chk("flush_count", Trace_Count, 2);
                idle(1'b0, 1'b0);
                chk("flush_no_c", Word_Out, NOP);
                chk("flush_no_c_count", Trace_Count, 2);

                idle(1'b1, 1'b0);
                chk("pop_tstate", Trace_State, 9'h011);
                idle(1'b0, 1'b1);
                chk("clear_count", Trace_Count, 0);

                for (int k = 1; k <= 10; k++)
                    tick(wrd(9'(k)), 9'(k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                idle(1'b0, 1'b0);
                chk("ovf_count", Trace_Count, 8);
                chk("ovf_flag",  Trace_Overflow, 1);
                for (int k = 0; k < 8; k++) begin
                    chk("ovf_pop_state", Trace_State, 9'(3 + k));
                    idle(1'b1, 1'b0);
                end
                chk("drained_state", Trace_State, 0);
                chk("drained_count", Trace_Count, 0);
                chk("ovf_sticky", Trace_Overflow, 1);
                idle(1'b1, 1'b0);
                chk("empty_pop_count", Trace_Count, 0);

                idle(1'b0, 1'b1);
                chk("clr_ovf", Trace_Overflow, 0);
                for (int k = 0; k < 9; k++)
                    tick(wrd(9'(32 + k)), 9'(32 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("full_count", Trace_Count, 8);
                chk("full_tstate", Trace_State, 9'h020);
                idle(1'b1, 1'b0);
                chk("pushpop_count", Trace_Count, 8);
                chk("pushpop_ovf",   Trace_Overflow, 0);
                chk("pushpop_tstate", Trace_State, 9'h021);

                tick(wrd(9'h029), 9'h029, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                tick(wrd(9'h02A), 9'h02A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("pre_clear_ovf", Trace_Overflow, 1);
                idle(1'b1, 1'b1);
                chk("clear_push_count", Trace_Count, 0);
                chk("clear_push_ovf",   Trace_Overflow, 0);

                tick(wrd(9'h030), 9'h030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                tick(wrd(9'h031), 9'h031, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                tick(wrd(9'h032), 9'h032, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
                chk("pre_arst_valid", Word_Out_Valid, 1);
                #2 Reset_n = 1'b0;
                #1;
                chk("arst_word",  Word_Out, NOP);
                chk("arst_valid", Word_Out_Valid, 0);
                chk("arst_state", State_Out, 0);
                chk("arst_count", Trace_Count, 0);
                chk("arst_tstate", Trace_State, 0);
                @(negedge Clock);
                #2 Reset_n = 1'b1;
                tick(wrd(9'h040), 9'h040, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                tick(wrd(9'h041), 9'h041, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
                chk("post_arst_word", Word_Out, wrd(9'h040));
                idle(1'b0, 1'b0);
                idle(1'b0, 1'b0);
            end
            begin : watchdog
                #200000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "bench did not complete");
            end
        join_any
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/microinstruction_pipe_register.md
# microinstruction_pipe_register

Parametrised successor to the single-stage control register. It captures the control word and state number from the Microstore into a DEPTH-stage pipeline on the falling edge of Clock. It adds:
- stall and flush control;
- a valid bit per stage;
- an asynchronous active-low reset to a programmable NOP word;
- a trace FIFO of recently executed state numbers for debugging.

It sits between the Microstore and the datapath control inputs. The next-state logic reads its feedback fields from the output word.

## Interface
- WIDTH, 64, control word width in bits (load enables, mux selects, memory and feedback fields concatenated)
- STATE_W, 9, state number width
- DEPTH, 1, pipeline stages (≥1)
- TRACE_DEPTH, 8, trace FIFO entries (power of two, ≥2)
- NOP_WORD, {WIDTH{1'b0}}, word loaded on reset or flush (all load enables deasserted)
- Clock  in  1  system clock; all state updates on negedge
- Reset_n  in  1  asynchronous, active-low reset
- Word_In  in  WIDTH  control word from Microstore
- State_In  in  STATE_W  state number for Word_In
- Word_Valid  in  1  Word_In is a real microinstruction
- Stall  in  1  hold all stages
- Flush  in  1  replace all stages with NOP_WORD, valid 0
- Word_Out  out  WIDTH  last-stage control word
- State_Out  out  STATE_W  last-stage state number
- Word_Out_Valid  out  1  last-stage valid
- Trace_Rd  in  1  pop oldest trace entry
- Trace_Clear  in  1  empty trace FIFO, clear overflow
- Trace_State  out  STATE_W  oldest trace entry (first-word fall-through), 0 when empty
- Trace_Count  out  $clog2(TRACE_DEPTH+1)  entries held
- Trace_Overflow  out  1  sticky: an entry was overwritten

## Operation
- Reset (Reset_n=0, asynchronous):
  - every stage word = NOP_WORD, state = 0, valid = 0;
  - trace pointers = 0, Trace_Count = 0, Trace_Overflow = 0.
- Pipeline, per falling edge, in priority order:
  1. Flush: all stages load NOP_WORD, state 0, valid 0. Flush overrides Stall and discards Word_In.
  2. Stall: all stages hold, including valid bits. Word_In is not captured.
  3. Otherwise: stage[0] ← {Word_In, State_In, Word_Valid} and stage[i] ← stage[i-1].
- An invalid word (Word_Valid=0) still enters its stage, with its valid bit cleared.
- Outputs Word_Out, State_Out and Word_Out_Valid come directly from the last stage's registers, not through combinational logic.
- Trace push: occurs on an advancing edge (no Flush, no Stall) when the word entering the last stage is valid. The pushed value is that word's state number.
- Trace pop: Trace_Rd=1 and Trace_Count>0 advance the read pointer. A pop on empty is ignored.
- Trace FIFO boundary cases:
  - Full + push without pop: overwrite the oldest entry, advance both pointers, count stays TRACE_DEPTH, set Trace_Overflow.
  - Push + pop on the same edge: both happen, count unchanged, no overflow even when full.
  - Trace_Clear: overrides push and pop on that edge; empties the FIFO and clears Trace_Overflow.
- Pointers are log2(TRACE_DEPTH) bits and wrap modulo TRACE_DEPTH.

## Timing
- Latency: a word presented before falling edge n appears on Word_Out after edge n+DEPTH-1, given no stalls.
- Each stalled edge adds one edge of latency.
- Flush takes effect at the edge where it is sampled. Word_Out_Valid=0 immediately after that edge.
- Trace push is visible on Trace_Count after the same edge that loads the last stage.
- Trace_State updates combinationally from the read pointer and memory after each edge.
- Reset deassertion is asynchronous to Clock. The first capture happens on the first falling edge with Reset_n=1.
- Reset asserted mid-stall or mid-flush: all outputs return to their reset values immediately, without waiting for Clock.

## Test plan
- Reset and latency, DEPTH=2:
  - Hold Reset_n=0 → Word_Out=NOP_WORD, valid 0, Trace_Count 0.
  - Release, present words A (state 0x010) then B (0x011) on consecutive edges → A appears on Word_Out after the 2nd edge and B after the 3rd; trace holds 0x010, 0x011.
- Stall: with stage[0]=B and last stage=A, hold Stall for 3 edges → Word_Out stays A, Trace_Count stays unchanged; after release, B appears on the next edge.
- Flush priority: assert Stall and Flush together with valid C on Word_In → all stages become NOP_WORD, valid 0; C is never observed and no trace push occurs.
- Trace overflow, TRACE_DEPTH=8: retire 10 valid states 1..10 with no pops → Trace_Count=8, Trace_Overflow=1. Then pop 8 times → Trace_State reads 3..10, then 0 with count 0.
- Trace edge cases:
  - Full FIFO with simultaneous push and Trace_Rd → count stays 8, overflow stays 0 (starting from a cleared flag).
  - Trace_Clear asserted together with a push → count 0, overflow 0.
- Asynchronous reset mid-stream: drop Reset_n between clock edges → outputs go to their reset values before the next falling edge.
